// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcode and FSM state encodings shared by the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_ADD2  = 3'b010;
  localparam logic [2:0] OP_SUB2  = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_MAX   = 3'b101;
  localparam logic [2:0] OP_ABS   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift_mul.sv
// ============================================================================
// Module      : alu_shift_mul
// Description : HALF x HALF unsigned shift-add multiplier, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_mul #(
  parameter int HALF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HALF-1:0]   mcand,
  input  logic [HALF-1:0]   mplier,
  output logic              busy,
  output logic              done,
  output logic [2*HALF-1:0] product
);

  localparam int CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(HALF);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  logic [2*HALF-1:0] r_mcand;
  logic [HALF-1:0]   r_mplier;
  logic [2*HALF-1:0] r_acc;
  logic [CW-1:0]     r_count;
  logic              r_busy;

  logic [2*HALF-1:0] w_addend;
  logic [2*HALF-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  // product is the accumulator after this cycle's step, so the owner can
  // capture the final value on the same edge that done is high.
  assign product = w_acc_next;
  assign done    = r_busy && (r_count == C_CNT_ONE);
  assign busy    = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{HALF{1'b0}}, mcand};
      r_mplier <= mplier;
      r_acc    <= '0;
      r_count  <= C_CNT_INIT;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - C_CNT_ONE;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Registered 8-function ALU with valid/ready in and out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH+1:0] w_add2;
  logic [WIDTH+1:0] w_sub2;
  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] w_max;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (select == OP_MUL);

  alu_shift_mul #(
    .HALF (HALF)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .mcand   (a[HALF-1:0]),
    .mplier  (b[HALF-1:0]),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // ADD2/SUB2 use two guard bits so carry/borrow reflect the exact result.
  assign w_add  = {1'b0, a} + {1'b0, b};
  assign w_sub  = {1'b0, a} - {1'b0, b};
  assign w_add2 = {2'b00, a} + {1'b0, b, 1'b0};
  assign w_sub2 = {2'b00, a} - {1'b0, b, 1'b0};
  assign w_abs  = a[MSB] ? -a : a;
  assign w_max  = ($signed(a) >= $signed(b)) ? a : b;

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (select)
      OP_ADD: begin
        w_alu_res   = w_add[WIDTH-1:0];
        w_alu_carry = w_add[WIDTH];
        w_alu_ovf   = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_res   = w_sub[WIDTH-1:0];
        w_alu_carry = w_sub[WIDTH];
        w_alu_ovf   = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
      end
      OP_ADD2: begin
        w_alu_res   = w_add2[WIDTH-1:0];
        w_alu_carry = |w_add2[WIDTH+1:WIDTH];
      end
      OP_SUB2: begin
        w_alu_res   = w_sub2[WIDTH-1:0];
        w_alu_carry = w_sub2[WIDTH+1];
      end
      OP_MAX:   w_alu_res = w_max;
      OP_ABS: begin
        w_alu_res = w_abs;
        w_alu_ovf = (a == C_MIN_NEG);
      end
      OP_PASSB: w_alu_res = b;
      default:  w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (select == OP_MUL) begin
              r_state     <= ST_MUL;
              r_out_valid <= 1'b0;
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_neg       <= w_alu_res[MSB];
              r_carry     <= w_alu_carry;
              r_ovf       <= w_alu_ovf;
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_result    <= w_mul_product;
            r_zero      <= (w_mul_product == '0);
            r_neg       <= w_mul_product[MSB];
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign flag_zero  = r_zero;
  assign flag_neg   = r_neg;
  assign flag_carry = r_carry;
  assign flag_ovf   = r_ovf;

endmodule

`default_nettype wire
